// File: rtl/core_pkg.sv
// +-----------------------------------------------------------------+
// | core_pkg : shared op and state encodings for the shifter.        |
// | Rev 1.0                                                          |
// +-----------------------------------------------------------------+
`default_nettype none

package core_pkg;

  localparam logic [1:0] SH_SLL = 2'b00;
  localparam logic [1:0] SH_SRL = 2'b01;
  localparam logic [1:0] SH_SRA = 2'b11;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'b00,
    ST_SHIFT = 2'b01,
    ST_DONE  = 2'b10
  } state_t;

endpackage

`default_nettype wire

// File: rtl/shift_step.sv
// +-----------------------------------------------------------------+
// | shift_step : single-bit-position SLL/SRL/SRA, purely combinational.|
// | Rev 1.0                                                          |
// +-----------------------------------------------------------------+
`default_nettype none

module shift_step
  import core_pkg::*;
#(
  parameter int WIDTH = 32
) (
  input  logic [WIDTH-1:0] data_i,
  input  logic [1:0]       op_i,
  output logic [WIDTH-1:0] data_o
);

  logic w_fill;

  // Reserved op 2'b10 falls into the logical-right path along with SRL.
  always_comb begin
    w_fill = (op_i == SH_SRA) ? data_i[WIDTH-1] : 1'b0;
    if (op_i == SH_SLL) begin
      data_o = {data_i[WIDTH-2:0], 1'b0};
    end else begin
      data_o = {w_fill, data_i[WIDTH-1:1]};
    end
  end

endmodule

`default_nettype wire

// File: rtl/iter_shift_unit.sv
// +-----------------------------------------------------------------+
// | iter_shift_unit : multi-cycle RV32 shifter, one bit per clock.   |
// | Rev 1.0                                                          |
// +-----------------------------------------------------------------+
`default_nettype none

module iter_shift_unit
  import core_pkg::*;
#(
  parameter int WIDTH = 32,
  parameter int SHW   = 5
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             start,
  input  logic [1:0]       op,
  input  logic [WIDTH-1:0] operand,
  input  logic [SHW-1:0]   amount,
  input  logic             kill,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] result
);

  localparam logic [SHW-1:0] c_count_one = SHW'(1);

  state_t           state_q,  state_d;
  logic [WIDTH-1:0] result_q, result_d;
  logic [SHW-1:0]   count_q,  count_d;
  logic [1:0]       op_q,     op_d;
  logic [WIDTH-1:0] w_step;

  shift_step #(
    .WIDTH (WIDTH)
  ) u_shift_step (
    .data_i (result_q),
    .op_i   (op_q),
    .data_o (w_step)
  );

  always_comb begin
    state_d  = state_q;
    result_d = result_q;
    count_d  = count_q;
    op_d     = op_q;
    if (kill) begin
      state_d = ST_IDLE;
    end else begin
      case (state_q)
        ST_IDLE, ST_DONE: begin
          if (start) begin
            result_d = operand;
            count_d  = amount;
            op_d     = op;
            state_d  = (amount == '0) ? ST_DONE : ST_SHIFT;
          end else begin
            state_d  = ST_IDLE;
          end
        end
        ST_SHIFT: begin
          result_d = w_step;
          count_d  = count_q - c_count_one;
          if (count_q == c_count_one) begin
            state_d = ST_DONE;
          end
        end
        default: state_d = ST_IDLE;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q  <= ST_IDLE;
      result_q <= '0;
      count_q  <= '0;
      op_q     <= SH_SLL;
    end else begin
      state_q  <= state_d;
      result_q <= result_d;
      count_q  <= count_d;
      op_q     <= op_d;
    end
  end

  // Status flags come straight from the state register, never from inputs.
  assign busy   = (state_q != ST_IDLE);
  assign done   = (state_q == ST_DONE);
  assign result = result_q;

endmodule

`default_nettype wire

// File: tb/tb_iter_shift_unit.sv
// +-----------------------------------------------------------------+
// | tb_iter_shift_unit : directed self-checking bench for the shifter.|
// | Rev 1.0                                                          |
// +-----------------------------------------------------------------+
`default_nettype none

module tb_iter_shift_unit;

  localparam int WIDTH = 32;
  localparam int SHW   = 5;

  logic             clk;
  logic             reset;
  logic             start;
  logic [1:0]       op;
  logic [WIDTH-1:0] operand;
  logic [SHW-1:0]   amount;
  logic             kill;
  logic             busy;
  logic             done;
  logic [WIDTH-1:0] result;

  int n_checks;
  int n_errors;

  iter_shift_unit #(
    .WIDTH (WIDTH),
    .SHW   (SHW)
  ) dut (
    .clk     (clk),
    .reset   (reset),
    .start   (start),
    .op      (op),
    .operand (operand),
    .amount  (amount),
    .kill    (kill),
    .busy    (busy),
    .done    (done),
    .result  (result)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%08h, expected 0x%08h", tag, act, exp);
    end
  endtask

  // Launch one op, scramble inputs after acceptance, then time the done pulse.
  task automatic run_op(input string tag, input logic [1:0] o, input logic [31:0] val,
                        input logic [4:0] amt, input logic [31:0] exp);
    int c;
    op = o; operand = val; amount = amt; start = 1'b1;
    tick();
    start = 1'b0; operand = 32'hA5A5_5A5A; amount = 5'd7; op = 2'b00;
    c = 1;
    while (!done && c < 40) begin
      check({tag, " busy"}, {31'd0, busy}, 32'd1);
      tick();
      c++;
    end
    check({tag, " latency"}, c, {27'd0, amt} + 32'd1);
    check({tag, " done"}, {31'd0, done}, 32'd1);
    check({tag, " busy@done"}, {31'd0, busy}, 32'd1);
    check({tag, " result"}, result, exp);
    tick();
    check({tag, " done pulse"}, {31'd0, done}, 32'd0);
    check({tag, " idle"}, {31'd0, busy}, 32'd0);
    check({tag, " hold"}, result, exp);
  endtask

  initial begin
    int ndone;
    int cdone;
    n_checks = 0; n_errors = 0;
    reset = 1'b1; start = 1'b0; kill = 1'b0; op = 2'b00; operand = '0; amount = '0;
    tick();
    check("rst busy", {31'd0, busy}, 32'd0);
    check("rst done", {31'd0, done}, 32'd0);
    check("rst result", result, 32'd0);
    tick();
    reset = 1'b0;

    // Basic ops and sign handling
    run_op("sll4", 2'b00, 32'h0000_0001, 5'd4, 32'h0000_0010);
    run_op("sra31", 2'b11, 32'h8000_0000, 5'd31, 32'hFFFF_FFFF);
    run_op("srl31", 2'b01, 32'h8000_0000, 5'd31, 32'h0000_0001);
    run_op("sra pos", 2'b11, 32'h4000_0000, 5'd4, 32'h0400_0000);
    run_op("rsvd", 2'b10, 32'h8000_0080, 5'd3, 32'h1000_0010);

    // Zero amount plus back-to-back issue from DONE
    op = 2'b01; operand = 32'hDEAD_BEEF; amount = 5'd0; start = 1'b1;
    tick();
    check("b2b done1", {31'd0, done}, 32'd1);
    check("b2b res1", result, 32'hDEAD_BEEF);
    op = 2'b00; operand = 32'h0000_0001; amount = 5'd1; start = 1'b1;
    tick();
    start = 1'b0;
    check("b2b c2 done", {31'd0, done}, 32'd0);
    check("b2b c2 busy", {31'd0, busy}, 32'd1);
    tick();
    check("b2b done2", {31'd0, done}, 32'd1);
    check("b2b res2", result, 32'h0000_0002);
    tick();

    // Starts while shifting must be ignored
    op = 2'b00; operand = 32'h0000_0003; amount = 5'd10; start = 1'b1;
    tick();
    start = 1'b0;
    ndone = 0; cdone = 0;
    for (int c = 1; c <= 15; c++) begin
      if (done) begin
        ndone++;
        cdone = c;
        check("ign result", result, 32'h0000_0C00);
      end
      if (c >= 2 && c <= 5) begin
        start = 1'b1; operand = 32'hFFFF_FFFF; amount = 5'd3; op = 2'b01;
      end else begin
        start = 1'b0;
      end
      tick();
    end
    check("ign ndone", ndone, 32'd1);
    check("ign cycle", cdone, 32'd11);

    // Kill with simultaneous start
    op = 2'b11; operand = 32'h8000_0000; amount = 5'd8; start = 1'b1;
    tick();
    start = 1'b0;
    tick();
    kill = 1'b1; start = 1'b1;
    tick();
    kill = 1'b0; start = 1'b0;
    check("kill busy", {31'd0, busy}, 32'd0);
    check("kill done", {31'd0, done}, 32'd0);
    ndone = 0;
    for (int c = 0; c < 12; c++) begin
      if (done || busy) ndone++;
      tick();
    end
    check("kill quiet", ndone, 32'd0);

    // Reset in the middle of a shift
    op = 2'b00; operand = 32'h0000_0001; amount = 5'd20; start = 1'b1;
    tick();
    start = 1'b0;
    for (int c = 1; c < 6; c++) tick();
    check("prerst busy", {31'd0, busy}, 32'd1);
    reset = 1'b1;
    tick();
    reset = 1'b0;
    check("mrst busy", {31'd0, busy}, 32'd0);
    check("mrst done", {31'd0, done}, 32'd0);
    check("mrst result", result, 32'd0);
    run_op("post rst", 2'b00, 32'h0000_0001, 5'd4, 32'h0000_0010);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule

`default_nettype wire
